// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned MulLatDefault = 3;
    localparam int unsigned DivLatDefault = 32;
    localparam int unsigned CntW          = 6;

    typedef enum logic [1:0] {
        IIdle,
        IWait,
        IDrop
    } ifsm_t;

    typedef enum logic {
        DIdle,
        DWait
    } dfsm_t;

endpackage

// File: rtl/mdu_timer.sv
// Multiply/divide occupancy counter: loads the op latency on issue, counts down to idle.
module mdu_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned DIV_LAT = DivLatDefault
) (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    input  logic div_i,
    input  logic stall_i,
    output logic busy_o
);

    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A start while E is held is the same op seen again next cycle, so it must not reload.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i && !stall_i) begin
            cnt_d = div_i ? DivLoad : MulLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: fetch/data handshake tracking,
// load-use and HI/LO interlocks, exception flush, all resolved into per-stage stall/bubble.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned DIV_LAT = DivLatDefault
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       f_ireq_i,
    input  logic       iresp_ok_i,
    input  logic       m_dreq_i,
    input  logic       dresp_ok_i,
    input  logic [4:0] d_src1_i,
    input  logic [4:0] d_src2_i,
    input  logic       d_use1_i,
    input  logic       d_use2_i,
    input  logic       d_hilo_i,
    input  logic [4:0] e_dst_i,
    input  logic       e_wen_i,
    input  logic       e_is_load_i,
    input  logic       e_mdu_start_i,
    input  logic       e_mdu_div_i,
    input  logic       exc_flush_i,
    output logic       f_stall_o,
    output logic       d_stall_o,
    output logic       e_stall_o,
    output logic       m_stall_o,
    output logic       d_bubble_o,
    output logic       e_bubble_o,
    output logic       m_bubble_o,
    output logic       w_bubble_o,
    output logic       mdu_busy_o
);

    ifsm_t ifsm_q;
    dfsm_t dfsm_q;

    logic dwait, iwait, lu, mh;
    logic src1_hit, src2_hit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ifsm_q <= IIdle;
            dfsm_q <= DIdle;
        end else begin
            case (ifsm_q)
                IIdle: if (f_ireq_i && !iresp_ok_i) ifsm_q <= IWait;
                IWait: begin
                    if (iresp_ok_i) begin
                        ifsm_q <= IIdle;
                    end else if (exc_flush_i) begin
                        ifsm_q <= IDrop;
                    end
                end
                // The word returned here belongs to the flushed path and is thrown away.
                IDrop: if (iresp_ok_i) ifsm_q <= IIdle;
                default: ifsm_q <= IIdle;
            endcase

            case (dfsm_q)
                DIdle: if (m_dreq_i && !dresp_ok_i) dfsm_q <= DWait;
                DWait: if (dresp_ok_i) dfsm_q <= DIdle;
                default: dfsm_q <= DIdle;
            endcase
        end
    end

    assign dwait = (m_dreq_i && !dresp_ok_i) || (dfsm_q == DWait && !dresp_ok_i);
    assign iwait = (f_ireq_i && !iresp_ok_i)
                || ((ifsm_q == IWait || ifsm_q == IDrop) && !iresp_ok_i)
                || (ifsm_q == IDrop);

    assign src1_hit = d_use1_i && (d_src1_i == e_dst_i);
    assign src2_hit = d_use2_i && (d_src2_i == e_dst_i);
    assign lu       = e_is_load_i && e_wen_i && (e_dst_i != 5'd0) && (src1_hit || src2_hit);
    assign mh       = mdu_busy_o && d_hilo_i;

    // Priority chain guarantees a stage never sees stall and bubble together.
    always_comb begin
        f_stall_o  = 1'b0;
        d_stall_o  = 1'b0;
        e_stall_o  = 1'b0;
        m_stall_o  = 1'b0;
        d_bubble_o = 1'b0;
        e_bubble_o = 1'b0;
        m_bubble_o = 1'b0;
        w_bubble_o = 1'b0;
        if (dwait) begin
            f_stall_o  = 1'b1;
            d_stall_o  = 1'b1;
            e_stall_o  = 1'b1;
            m_stall_o  = 1'b1;
            w_bubble_o = 1'b1;
        end else if (exc_flush_i) begin
            d_bubble_o = 1'b1;
            e_bubble_o = 1'b1;
            m_bubble_o = 1'b1;
        end else if (lu || mh) begin
            f_stall_o  = 1'b1;
            d_stall_o  = 1'b1;
            e_bubble_o = 1'b1;
        end else if (iwait) begin
            f_stall_o  = 1'b1;
            d_bubble_o = 1'b1;
        end
    end

    mdu_timer #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_mdu_timer (
        .clk    (clk),
        .resetn (resetn),
        .start_i(e_mdu_start_i),
        .div_i  (e_mdu_div_i),
        .stall_i(e_stall_o),
        .busy_o (mdu_busy_o)
    );

    // A flush cannot be committed while M still owns an outstanding data access.
    flush_vs_dmem_a : assert property (@(posedge clk) disable iff (!resetn)
        !(exc_flush_i && (m_dreq_i || dfsm_q == DWait)));

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and stall controller for the 5-stage pipeline. It generates every per-stage stall and bubble control, including the `W_bubble` input of the writeback register. It tracks three sources of wait:
- outstanding instruction-fetch handshakes,
- outstanding data-memory handshakes,
- multi-cycle multiply/divide occupancy.

It also detects load-use hazards and applies exception flushes. Its outputs feed directly into the F/D/E/M/W pipeline registers.

## Interface
Parameters:
- `MUL_LAT`, default 3: multiply busy cycles after issue.
- `DIV_LAT`, default 32: divide busy cycles after issue.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `f_ireq` in 1: F issues an instruction fetch this cycle.
- `iresp_ok` in 1: fetch data returned this cycle.
- `m_dreq` in 1: M issues a data load/store this cycle.
- `dresp_ok` in 1: data response this cycle.
- `d_src1`, `d_src2` in 5: D source registers.
- `d_use1`, `d_use2` in 1: the corresponding source is actually read.
- `d_hilo` in 1: D instruction reads HI/LO or is itself a mult/div.
- `e_dst` in 5: E destination register.
- `e_wen` in 1: E writes a register.
- `e_is_load` in 1: E instruction is a load.
- `e_mdu_start` in 1: E issues a mult/div.
- `e_mdu_div` in 1: that op is a divide.
- `exc_flush` in 1: exception/ERET commit in M; redirect PC this cycle.
- `F_stall`, `D_stall`, `E_stall`, `M_stall` out 1: hold the stage register.
- `D_bubble`, `E_bubble`, `M_bubble`, `W_bubble` out 1: clear the stage register at the next edge.
- `mdu_busy` out 1: MDU occupied.

## Operation
Internal state:
- **I-FSM** (`I_IDLE`, `I_WAIT`, `I_DROP`)
  - `I_IDLE` → `I_WAIT` on `f_ireq & ~iresp_ok`.
  - `I_WAIT` → `I_IDLE` on `iresp_ok`.
  - `I_WAIT` → `I_DROP` on `exc_flush & ~iresp_ok`.
  - `I_DROP` → `I_IDLE` on `iresp_ok`; the returned word is discarded.
- **D-FSM** (`D_IDLE`, `D_WAIT`)
  - `D_IDLE` → `D_WAIT` on `m_dreq & ~dresp_ok`.
  - `D_WAIT` → `D_IDLE` on `dresp_ok`.
- **MDU counter**, 6 bits.
  - On `e_mdu_start & ~E_stall`, it loads `MUL_LAT` or `DIV_LAT`; otherwise it decrements while nonzero.
  - `mdu_busy = (cnt != 0)`.

Combinational conditions:
- `dwait = m_dreq & ~dresp_ok | D_WAIT & ~dresp_ok`
- `iwait = f_ireq & ~iresp_ok | (I_WAIT|I_DROP) & ~iresp_ok | I_DROP`
- `lu = e_is_load & e_wen & e_dst != 0 & (d_use1 & d_src1 == e_dst | d_use2 & d_src2 == e_dst)`
- `mh = mdu_busy & d_hilo`

Priority (highest first):
1. `dwait`: `F_stall`, `D_stall`, `E_stall`, `M_stall` = 1; `W_bubble` = 1.
2. `exc_flush`: `D_bubble`, `E_bubble`, `M_bubble` = 1; no stalls.
3. `lu | mh`: `F_stall`, `D_stall` = 1; `E_bubble` = 1.
4. `iwait`: `F_stall` = 1; `D_bubble` = 1.
5. Otherwise all outputs 0.

A stall and a bubble are never both asserted for the same stage. When both apply, the stall wins, e.g. `dwait` suppresses `iwait`'s `D_bubble`.

Protocol rules:
- `exc_flush` must never coincide with `m_dreq` or `D_WAIT`. This is checked by an assertion.
- A flush does not abort the MDU. It does cancel a fetch in flight via `I_DROP`.

## Timing
- Outputs are Mealy: they are combinational from the current inputs and registered state, and take effect at the next `clk` edge.
- Reset state: `I_IDLE`, `D_IDLE`, `cnt` = 0. With all inputs 0, every output is 0.
- Reset asserted mid-wait forces the idle states and `cnt` = 0 at that edge. Any pending response is then ignored.
- Zero-wait handshake (`req` and `ok` in the same cycle): no stall and no state change.
- MDU: after issue at cycle t, `mdu_busy` is high for cycles t+1 … t+LAT exactly. A `d_hilo` instruction proceeds in cycle t+LAT+1.
- `I_DROP`: `F_stall` and `D_bubble` stay high through the cycle `iresp_ok` arrives. The fetch resumes the following cycle.
- `e_mdu_start` while `E_stall` does not reload the counter.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the `ifsm_t` and `dfsm_t` enums,
  - the `MUL_LAT`/`DIV_LAT` defaults,
  - the 6-bit counter width constant.
- Sub-module `mdu_timer` holds the load/decrement counter and `mdu_busy`.
- The FSMs and priority logic stay in `pipe_ctrl`.

## Test plan
- **Load-use:** `e_is_load=1`, `e_wen=1`, `e_dst=5`, `d_use1=1`, `d_src1=5` → `F_stall=D_stall=E_bubble=1` for one cycle. With `e_dst=0` → all outputs 0.
- **D-cache wait:** `m_dreq=1`, `dresp_ok` at cycle +3 → `F/D/E/M_stall=1` and `W_bubble=1` for cycles 0–2; all 0 at cycle 3.
- **Divide:** `e_mdu_start=1`, `e_mdu_div=1`, then `d_hilo=1` held → `E_bubble=1` for exactly 32 cycles, then released. With `MUL_LAT=3` → 3 cycles.
- **Fetch flush:** `f_ireq` with `iresp_ok` delayed, then `exc_flush` in cycle 1, `iresp_ok` in cycle 4 → `D/E/M_bubble` in cycle 1, `F_stall=D_bubble=1` through cycle 4, FSM in `I_IDLE` at cycle 5.
- **Priority:** `dwait` together with `lu` together with `iwait` → only the `dwait` pattern appears (`D_bubble=0`, `E_bubble=0`).
- **Reset:** `resetn=0` during `D_WAIT` and `cnt=20` → next cycle all outputs 0, `mdu_busy=0`.
